// File: rtl/display_pkg.sv
// Shared types and constants for the display update path: FSM states,
// panel timing and field widths, plus the name length clamp helper.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COMMIT,
    ACK
  } upd_state_e;

  // 480x272 panel, 525x286 total including blanking
  localparam int H_ACTIVE = 480;
  localparam int V_ACTIVE = 272;
  localparam int H_TOTAL  = 525;
  localparam int V_TOTAL  = 286;

  localparam int NAME_LEN_W  = 6;
  localparam int FONT_W      = 2;
  localparam int PIX_W       = 10;
  localparam int FRAME_CNT_W = 16;

  // Requested lengths beyond the buffer capacity saturate at the capacity
  function automatic logic [NAME_LEN_W-1:0] clamp_len(
    input logic [NAME_LEN_W-1:0] len,
    input logic [NAME_LEN_W-1:0] max_len
  );
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/frame_blink_gen.sv
// Frame boundary detection, completed-frame counter and the frame-based
// blink gate that blanks the name every BLINK_FRAMES frames.
module frame_blink_gen #(
  parameter int H_ACTIVE     = 480,
  parameter int V_ACTIVE     = 272,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        tft_clock_9m,
  input  logic        system_reset_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        blink_en,
  output logic        frame_end,
  output logic [15:0] frame_count,
  output logic        display_visible
);
  import display_pkg::*;

  // BLINK_FRAMES=1 still needs a 1-bit counter that simply stays at 0
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [PIX_W-1:0] X_LAST     = PIX_W'(H_ACTIVE - 1);
  localparam logic [PIX_W-1:0] Y_LAST     = PIX_W'(V_ACTIVE - 1);

  logic [BW-1:0] blink_cnt;

  // Last active pixel of the last active line marks the frame boundary
  assign frame_end = (pix_x == X_LAST) && (pix_y == Y_LAST);

  // Completed-frame counter, free-running and wrapping
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n)  frame_count <= '0;
    else if (frame_end)   frame_count <= frame_count + FRAME_CNT_W'(1);
  end

  // Blink period counter; visibility flips each time a full period elapses
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n) begin
      blink_cnt       <= '0;
      display_visible <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt       <= '0;
      display_visible <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt       <= '0;
        display_visible <= ~display_visible;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_update_scheduler.sv
// Captures name/font updates over a four-phase req/ack handshake into a
// shadow set and publishes them to the renderer only at frame end, with a
// watchdog that forces the commit if pixel timing stalls.
module display_update_scheduler #(
  parameter int MAX_NAME_LENGTH = 10,
  parameter int H_ACTIVE        = 480,
  parameter int V_ACTIVE        = 272,
  parameter int BLINK_FRAMES    = 30,
  parameter int TIMEOUT_CYCLES  = 200000
) (
  input  logic                         tft_clock_9m,
  input  logic                         system_reset_n,
  input  logic                         upd_req,
  input  logic [8*MAX_NAME_LENGTH-1:0] name_in,
  input  logic [5:0]                   length_in,
  input  logic [1:0]                   font_in,
  input  logic                         blink_en,
  input  logic [9:0]                   pix_x,
  input  logic [9:0]                   pix_y,
  output logic                         upd_ack,
  output logic [8*MAX_NAME_LENGTH-1:0] name_buffer_o,
  output logic [5:0]                   name_length_o,
  output logic [1:0]                   font_size_o,
  output logic                         display_visible,
  output logic                         commit_pulse,
  output logic [15:0]                  frame_count,
  output logic                         timeout_flag
);
  import display_pkg::*;

  localparam int NAME_W = 8 * MAX_NAME_LENGTH;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]       WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NAME_LEN_W-1:0] LEN_MAX = NAME_LEN_W'(MAX_NAME_LENGTH);

  typedef struct packed {
    logic [NAME_W-1:0]     name;
    logic [NAME_LEN_W-1:0] len;
    logic [FONT_W-1:0]     font;
  } cfg_t;

  upd_state_e      state, state_nxt;
  cfg_t            shadow, active;
  logic [WD_W-1:0] wd_cnt;
  logic            req_q;
  logic            capture;
  logic            set_timeout;
  logic            frame_end;

  frame_blink_gen #(
    .H_ACTIVE     (H_ACTIVE),
    .V_ACTIVE     (V_ACTIVE),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_frame_blink (
    .tft_clock_9m    (tft_clock_9m),
    .system_reset_n  (system_reset_n),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .blink_en        (blink_en),
    .frame_end       (frame_end),
    .frame_count     (frame_count),
    .display_visible (display_visible)
  );

  // State register
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n) state <= IDLE;
    else                 state <= state_nxt;
  end

  // Next state; frame_end wins over the watchdog so a coincident hit is a normal commit
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (upd_req && !req_q) begin
          capture   = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (frame_end) begin
          state_nxt = COMMIT;
        end else if (wd_cnt == WD_LAST) begin
          state_nxt   = COMMIT;
          set_timeout = 1'b1;
        end
      end
      COMMIT: state_nxt = ACK;
      ACK: begin
        if (!upd_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign upd_ack = (state == ACK);

  // Request history so a level left high after a handshake is not re-captured
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n) req_q <= 1'b0;
    else                 req_q <= upd_req;
  end

  // Shadow set loaded on a fresh request
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n) begin
      shadow <= '0;
    end else if (capture) begin
      shadow.name <= name_in;
      shadow.len  <= clamp_len(length_in, LEN_MAX);
      shadow.font <= font_in;
    end
  end

  // Watchdog counts only while armed; held at zero everywhere else
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n)     wd_cnt <= '0;
    else if (state == ARMED) wd_cnt <= wd_cnt + 1'b1;
    else                     wd_cnt <= '0;
  end

  // Active set and its strobe both appear the cycle after COMMIT
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n) begin
      active       <= '0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= (state == COMMIT);
      if (state == COMMIT) active <= shadow;
    end
  end

  // Sticky record that a commit was forced by the watchdog
  always_ff @(posedge tft_clock_9m or negedge system_reset_n) begin
    if (!system_reset_n)  timeout_flag <= 1'b0;
    else if (set_timeout) timeout_flag <= 1'b1;
  end

  assign name_buffer_o = active.name;
  assign name_length_o = active.len;
  assign font_size_o   = active.font;

endmodule

// File: tb/tb_display_update_scheduler.sv
// Directed bench: a compressed raster around the frame-end corner drives
// pix_x/pix_y; expected commits are queued when requests are issued and
// checked when commit_pulse appears.
module tb_display_update_scheduler;
  localparam int MAXN = 10;
  localparam int BF   = 2;
  localparam int TO   = 5000;
  localparam int NW   = 8 * MAXN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          upd_req = 1'b0;
  logic          blink_en = 1'b0;
  logic [NW-1:0] name_in = '0;
  logic [5:0]    length_in = '0;
  logic [1:0]    font_in = '0;
  logic [9:0]    pix_x = '0;
  logic [9:0]    pix_y = '0;

  logic          upd_ack;
  logic [NW-1:0] name_buffer_o;
  logic [5:0]    name_length_o;
  logic [1:0]    font_size_o;
  logic          display_visible;
  logic          commit_pulse;
  logic [15:0]   frame_count;
  logic          timeout_flag;

  display_update_scheduler #(
    .MAX_NAME_LENGTH (MAXN),
    .H_ACTIVE        (480),
    .V_ACTIVE        (272),
    .BLINK_FRAMES    (BF),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .tft_clock_9m    (clk),
    .system_reset_n  (rst_n),
    .upd_req         (upd_req),
    .name_in         (name_in),
    .length_in       (length_in),
    .font_in         (font_in),
    .blink_en        (blink_en),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .upd_ack         (upd_ack),
    .name_buffer_o   (name_buffer_o),
    .name_length_o   (name_length_o),
    .font_size_o     (font_size_o),
    .display_visible (display_visible),
    .commit_pulse    (commit_pulse),
    .frame_count     (frame_count),
    .timeout_flag    (timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] name;
    logic [5:0]    len;
    logic [1:0]    font;
    logic          tflag;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   tick_no = 0;
  int   fe_tick = -100;
  int   pulses = 0;
  int   pulse_tick = 0;
  logic fe_drv = 1'b0;
  logic run_pix = 1'b0;

  task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int x, input int y);
    pix_x  = 10'(x);
    pix_y  = 10'(y);
    fe_drv = (pix_x == 10'd479) && (pix_y == 10'd271);
    if (fe_drv) fe_tick = tick_no;
  endtask

  // One clock: sample just after the edge, score any commit, then advance the raster
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    tick_no++;
    if (commit_pulse === 1'b1) begin
      pulses++;
      pulse_tick = tick_no;
      if (sb.size() == 0) begin
        chk("unexpected_commit", commit_pulse, 0);
      end else begin
        e = sb.pop_front();
        chk("commit_name",  name_buffer_o, e.name);
        chk("commit_len",   name_length_o, e.len);
        chk("commit_font",  font_size_o,   e.font);
        chk("commit_tflag", timeout_flag,  e.tflag);
      end
    end
    if (run_pix) begin
      if (pix_x == 10'd489) set_pix(470, (pix_y == 10'd285) ? 95 : int'(pix_y) + 1);
      else                  set_pix(int'(pix_x) + 1, int'(pix_y));
    end
  endtask

  task automatic request(input logic [NW-1:0] nm, input logic [5:0] len, input logic [1:0] fnt,
                         input logic [5:0] exp_len, input logic exp_tf);
    exp_t e;
    e.name = nm; e.len = exp_len; e.font = fnt; e.tflag = exp_tf;
    sb.push_back(e);
    name_in = nm; length_in = len; font_in = fnt; upd_req = 1'b1;
  endtask

  task automatic wait_commit(input int bound);
    int p0;
    int n;
    p0 = pulses;
    n  = 0;
    while (pulses == p0 && n < bound) begin
      tick();
      n++;
    end
    chk("commit_seen", pulses - p0, 1);
  endtask

  task automatic run_to_frame_end();
    int n;
    n = 0;
    while (!fe_drv && n < 5000) begin
      tick();
      n++;
    end
    chk("frame_end_reached", fe_drv, 1'b1);
    tick();
  endtask

  logic vis_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  int   t0;
  int   p0;

  initial begin
    // Reset then idle
    rst_n = 1'b0;
    set_pix(0, 0);
    repeat (5) tick();
    chk("rst_ack",     upd_ack, 0);
    chk("rst_name",    name_buffer_o, 0);
    chk("rst_len",     name_length_o, 0);
    chk("rst_font",    font_size_o, 0);
    chk("rst_visible", display_visible, 1);
    chk("rst_pulse",   commit_pulse, 0);
    chk("rst_frames",  frame_count, 0);
    chk("rst_tflag",   timeout_flag, 0);
    rst_n = 1'b1;
    tick();

    // Basic commit with the raster running
    set_pix(470, 100);
    run_pix = 1'b1;
    request({40'h0, "ALICE"}, 6'd5, 2'd2, 6'd5, 1'b0);
    repeat (20) tick();
    chk("early_len",    name_length_o, 0);
    chk("early_font",   font_size_o, 0);
    chk("early_pulses", pulses, 0);
    wait_commit(5000);
    chk("basic_latency", pulse_tick - fe_tick, 2);
    chk("basic_ack",     upd_ack, 1);
    tick();
    chk("pulse_one_cycle", commit_pulse, 0);
    chk("ack_held",        upd_ack, 1);
    chk("len_held",        name_length_o, 5);
    upd_req = 1'b0;
    tick();
    chk("ack_cleared", upd_ack, 0);
    chk("frames_after_basic", frame_count, 1);

    // Length clamp, with req dropped while armed
    request(80'h0102_0304_0506_0708_090A, 6'd15, 2'd1, 6'd10, 1'b0);
    tick();
    tick();
    upd_req = 1'b0;
    wait_commit(5000);
    chk("clamp_latency", pulse_tick - fe_tick, 2);
    chk("clamp_ack",     upd_ack, 1);
    chk("clamp_tflag",   timeout_flag, 0);
    tick();
    chk("clamp_ack_drop", upd_ack, 0);

    // Watchdog commit with pixel timing stalled at the origin
    run_pix = 1'b0;
    set_pix(0, 0);
    tick();
    request(80'hDEAD_BEEF_CAFE_F00D_1234, 6'd10, 2'd3, 6'd10, 1'b1);
    t0 = tick_no;
    wait_commit(TO + 50);
    chk("wd_latency", pulse_tick - t0, TO + 2);
    chk("wd_tflag",   timeout_flag, 1);
    upd_req = 1'b0;
    tick();

    // Normal update afterwards keeps the sticky flag
    set_pix(470, 250);
    run_pix = 1'b1;
    request(80'h5A5A_0000_1111_2222_3333, 6'd7, 2'd1, 6'd7, 1'b1);
    wait_commit(5000);
    chk("sticky_latency", pulse_tick - fe_tick, 2);
    chk("sticky_tflag",   timeout_flag, 1);
    upd_req = 1'b0;
    tick();

    // Async reset while armed aborts the capture and clears the active set
    set_pix(470, 100);
    name_in = 80'h7777_7777_7777_7777_7777; length_in = 6'd3; font_in = 2'd2;
    upd_req = 1'b1;
    repeat (3) tick();
    upd_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack",   upd_ack, 0);
    chk("arst_len",   name_length_o, 0);
    chk("arst_name",  name_buffer_o, 0);
    chk("arst_tflag", timeout_flag, 0);
    tick();
    rst_n = 1'b1;
    p0 = pulses;
    run_to_frame_end();
    repeat (4) tick();
    chk("arst_no_commit", pulses - p0, 0);
    chk("arst_ack_idle",  upd_ack, 0);
    chk("arst_len_idle",  name_length_o, 0);
    chk("arst_frames",    frame_count, 1);

    // Blink over 6 frames from a clean reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    set_pix(470, 260);
    blink_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      run_to_frame_end();
      chk($sformatf("blink_f%0d", k + 1), display_visible, vis_tab[k]);
    end
    chk("blink_frames", frame_count, 6);
    blink_en = 1'b0;
    tick();
    chk("blink_off_visible", display_visible, 1);

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_update_scheduler.md
Name: display_update_scheduler

Overview:
- Sits between Name_Manipulation and Glyph_Renderer in the tft_clock_9m domain.
- Captures a new name/font configuration through a four-phase req/ack handshake and holds it in shadow registers.
- Commits the shadow set to the active outputs only at frame end, so the renderer never shows a torn frame.
- Also provides frame counting, a frame-based blink gate, and a watchdog commit for when pixel timing is stalled.

Parameters:
- MAX_NAME_LENGTH, 10: character slots; bus width 8*MAX_NAME_LENGTH.
- H_ACTIVE, 480: active pixels per line.
- V_ACTIVE, 272: active lines per frame.
- BLINK_FRAMES, 30: frames per blink half-period; must be ≥1.
- TIMEOUT_CYCLES, 200000: ARMED cycles before a forced commit; must exceed one frame (525*286 = 150150).

Ports:
- tft_clock_9m  in  1  sole clock.
- system_reset_n  in  1  asynchronous, active-low reset.
- upd_req  in  1  update request level, already synchronised into this domain.
- name_in  in  8*MAX_NAME_LENGTH  requested name, byte 0 in bits [7:0].
- length_in  in  6  requested length.
- font_in  in  2  requested font size.
- blink_en  in  1  enables blinking of the name.
- pix_x  in  10  current pixel x from tft_control.
- pix_y  in  10  current pixel y from tft_control.
- upd_ack  out  1  handshake acknowledge.
- name_buffer_o  out  8*MAX_NAME_LENGTH  active name to Glyph_Renderer.
- name_length_o  out  6  active length.
- font_size_o  out  2  active font size.
- display_visible  out  1  blink gate; renderer blanks glyphs when 0.
- commit_pulse  out  1  one-cycle strobe when the active set updates.
- frame_count  out  16  completed frames, wraps.
- timeout_flag  out  1  sticky; set by a watchdog commit.

Behaviour:
- Reset (async assert, sync release by clocking):
  - All outputs 0, except display_visible=1.
  - FSM=IDLE; shadow registers 0; watchdog, frame and blink counters 0.
- frame_end = (pix_x==H_ACTIVE-1) && (pix_y==V_ACTIVE-1), evaluated combinationally each cycle.
  - frame_count increments by 1 the cycle after frame_end; 0xFFFF wraps to 0.
- FSM:
  - IDLE: when upd_req=1, capture name_in, font_in and clamped length into shadow; go to ARMED. Clamp rule: length_in>MAX_NAME_LENGTH loads MAX_NAME_LENGTH.
  - ARMED: watchdog increments each cycle.
    - On frame_end, go to COMMIT.
    - When the watchdog reaches TIMEOUT_CYCLES-1, go to COMMIT and set timeout_flag.
    - If both occur in the same cycle, go to COMMIT without setting timeout_flag.
    - upd_req falling while ARMED is ignored; the capture stands.
  - COMMIT: one cycle. Copy shadow to the active outputs, registered so they are visible the next cycle. commit_pulse=1 for exactly that next cycle. Clear watchdog. Go to ACK.
  - ACK: upd_ack=1. Stay until upd_req=0, then upd_ack=0 the next cycle and go to IDLE.
  - A request still high on return to IDLE is not re-captured; a fresh rising edge of upd_req is required.
- Latency, req to active outputs: at most one frame (≤150150 cycles) plus 2 cycles; minimum 3 cycles when req arrives just before frame_end.
- Blink:
  - blink_en=0: display_visible=1 and blink counter held at 0.
  - blink_en=1: counter increments on each frame_end. When it reaches BLINK_FRAMES-1 it returns to 0 and display_visible toggles.
  - Deasserting blink_en mid-period restores visible=1 the next cycle.
- timeout_flag clears only on reset.
- Reset asserted mid-operation: the handshake aborts, upd_ack drops immediately, and the active set returns to 0.

Decomposition:
- Shared package display_pkg holds:
  - FSM state enum (IDLE, ARMED, COMMIT, ACK).
  - Panel timing constants: H_ACTIVE, V_ACTIVE, H_TOTAL=525, V_TOTAL=286.
  - Width constants: NAME_LEN_W=6, FONT_W=2.
- One natural sub-module, frame_blink_gen: frame_end detection, frame_count and blink counter/toggle. The top keeps the FSM, shadow/active registers and watchdog.

Test Plan:
- Reset then idle: system_reset_n low for 5 cycles → all outputs 0, display_visible=1, upd_ack=0.
- Basic commit:
  - Stimulus: req with name "ALICE", length 5, font 2 at pix_y=100, pixels running.
  - Response: active outputs unchanged until frame_end (479,271). name_length_o=5 and font_size_o=2 one cycle after COMMIT, with one commit_pulse. upd_ack stays high until req drops, then clears.
- Length clamp: length_in=15 with MAX_NAME_LENGTH=10 → name_length_o=10 after commit.
- Watchdog: pix_x/pix_y held at 0 and req asserted → commit after exactly TIMEOUT_CYCLES ARMED cycles, timeout_flag=1, and it stays set across a later normal update.
- Blink: blink_en=1, BLINK_FRAMES=2, 6 frames → display_visible toggles every 2 frames (1,0,1,0 pattern); frame_count=6. Dropping blink_en → visible=1 next cycle.
- Reset during ARMED:
  - Stimulus: async reset pulse mid-frame after capture.
  - Response: FSM in IDLE, no commit_pulse at the next frame_end, active set 0.
